// File: rtl/calc_pkg.sv
// calc_pkg: shared definitions for the calculator control FSM.
// Holds state encodings, 3-bit command codes and command-decode helpers.
package calc_pkg;

  // Control states; the numeric values are visible on state_out.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_NUM_A   = 3'd1,
    ST_WAIT_OP = 3'd2,
    ST_NUM_B   = 3'd3,
    ST_EXEC    = 3'd4,
    ST_SHOW    = 3'd5,
    ST_ERR     = 3'd6,
    ST_UNUSED  = 3'd7
  } state_e;

  // Command codes, decoded from the low three bits of cmd_code.
  localparam logic [2:0] CMD_CLEAR = 3'b000;
  localparam logic [2:0] CMD_DIGIT = 3'b001;
  localparam logic [2:0] CMD_ENTER = 3'b010;
  localparam logic [2:0] CMD_RSVD  = 3'b011;
  localparam logic [2:0] OP_ADD    = 3'b100;
  localparam logic [2:0] OP_SUB    = 3'b101;
  localparam logic [2:0] OP_MUL    = 3'b110;
  localparam logic [2:0] OP_DIV    = 3'b111;

  // Register strobes driven towards the datapath, grouped for one-shot defaults.
  typedef struct packed {
    logic load_number;
    logic clear_number;
    logic load_opcode;
    logic clear_opcode;
    logic load_result;
    logic clear_result;
  } strobe_t;

  // Any code with the top bit set is an arithmetic operator.
  function automatic logic is_op(input logic [2:0] code);
    return code[2];
  endfunction

endpackage

// File: rtl/calc_ctrl_fsm_if.sv
// calc_ctrl_fsm_if: command handshake plus register-strobe bundle between
// the keypad/datapath side (master) and the control FSM (slave).
interface calc_ctrl_fsm_if #(
  parameter int OPCODE_W = 3
) ();

  logic                cmd_valid;
  logic [OPCODE_W-1:0] cmd_code;
  logic                cmd_ready;
  logic                alu_err;
  logic                load_number;
  logic                clear_number;
  logic                load_opcode;
  logic                clear_opcode;
  logic                load_result;
  logic                clear_result;
  logic                sel_mux_alu;
  logic                sel_mux_display;
  logic [OPCODE_W-1:0] opcode_out;
  logic [2:0]          state_out;
  logic                err;

  // Command source and datapath: issues commands and ALU status, observes strobes.
  modport master (
    output cmd_valid, cmd_code, alu_err,
    input  cmd_ready, load_number, clear_number, load_opcode, clear_opcode,
           load_result, clear_result, sel_mux_alu, sel_mux_display,
           opcode_out, state_out, err
  );

  // Control FSM: consumes commands and ALU status, drives strobes and selects.
  modport slave (
    input  cmd_valid, cmd_code, alu_err,
    output cmd_ready, load_number, clear_number, load_opcode, clear_opcode,
           load_result, clear_result, sel_mux_alu, sel_mux_display,
           opcode_out, state_out, err
  );

endinterface

// File: rtl/calc_lat_counter.sv
// calc_lat_counter: counts the ALU_LATENCY cycles spent in EXEC.
// Loaded on entry to EXEC, decrements while enabled, flags the final cycle.
module calc_lat_counter #(
  parameter int ALU_LATENCY = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  input  logic en_i,
  output logic last_o
);

  localparam int CW = $clog2(ALU_LATENCY + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: reload on EXEC entry, otherwise step down towards zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CW'(ALU_LATENCY);
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A zero count can only appear after corruption; treat it as final so EXEC cannot stall.
  assign last_o = (cnt_q <= CW'(1));

endmodule

// File: rtl/calc_ctrl_fsm.sv
// calc_ctrl_fsm: control FSM for the calculator datapath.
// Accepts keypad commands over a valid/ready handshake, sequences operand
// entry (with a per-operand digit limit), a multi-cycle ALU wait, chained
// operations and an error state. All strobes are registered one-cycle pulses.
// Optional feature macro: CALC_REPEAT_EN (ENTER in SHOW repeats the last op
// and operand B is kept in the number register after EXEC).
module calc_ctrl_fsm
  import calc_pkg::*;
#(
  parameter int OPCODE_W    = 3,
  parameter int MAX_DIGITS  = 8,
  parameter int ALU_LATENCY = 1
) (
  input logic            clk,
  input logic            reset,
  calc_ctrl_fsm_if.slave bus
);

  localparam int DW = $clog2(MAX_DIGITS + 1);

  state_e              state_q, state_d;
  logic [DW-1:0]       dcnt_q, dcnt_d;
  logic [OPCODE_W-1:0] opcode_q, opcode_d;
  strobe_t             stb_q, stb_d;
  logic                sel_alu_q, sel_alu_d;
  logic                sel_disp_q, sel_disp_d;
  logic                err_q, err_d;

  logic [2:0]          code3_s;
  logic                cmd_ready_s;
  logic                cmd_acc_s;
  logic                lat_load_s;
  logic                lat_last_s;
  logic                exec_done_s;

  assign code3_s = bus.cmd_code[2:0];

  // A DIGIT arriving in SHOW is held off one cycle while the display is cleared.
  assign cmd_ready_s = !reset && (state_q != ST_EXEC) &&
                       !((state_q == ST_SHOW) && bus.cmd_valid && (code3_s == CMD_DIGIT));
  assign cmd_acc_s   = bus.cmd_valid && cmd_ready_s;

  calc_lat_counter #(
    .ALU_LATENCY (ALU_LATENCY)
  ) u_lat (
    .clk    (clk),
    .reset  (reset),
    .load_i (lat_load_s),
    .en_i   (state_q == ST_EXEC),
    .last_o (lat_last_s)
  );

  // Next-state, digit count, opcode and strobe decisions.
  always_comb begin
    state_d     = state_q;
    dcnt_d      = dcnt_q;
    opcode_d    = opcode_q;
    stb_d       = '0;
    exec_done_s = 1'b0;

    if (cmd_acc_s && (code3_s == CMD_CLEAR)) begin
      // CLEAR wipes everything from any state that can accept it, ERR included.
      stb_d.clear_number = 1'b1;
      stb_d.clear_opcode = 1'b1;
      stb_d.clear_result = 1'b1;
      opcode_d           = '0;
      dcnt_d             = '0;
      state_d            = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_acc_s && (code3_s == CMD_DIGIT)) begin
            stb_d.load_number = 1'b1;
            dcnt_d            = DW'(1);
            state_d           = ST_NUM_A;
          end else begin
            state_d = ST_IDLE;
          end
        end

        ST_NUM_A: begin
          if (!cmd_acc_s) begin
            state_d = ST_NUM_A;
          end else if (code3_s == CMD_DIGIT) begin
            if (dcnt_q < DW'(MAX_DIGITS)) begin
              stb_d.load_number = 1'b1;
              dcnt_d            = dcnt_q + DW'(1);
            end else begin
              dcnt_d = dcnt_q;
            end
          end else if (code3_s == CMD_ENTER) begin
            // Operand A moves to the result register straight through the mux.
            stb_d.load_result  = 1'b1;
            stb_d.clear_number = 1'b1;
            state_d            = ST_WAIT_OP;
          end else if (is_op(code3_s)) begin
            stb_d.load_result  = 1'b1;
            stb_d.clear_number = 1'b1;
            stb_d.load_opcode  = 1'b1;
            opcode_d           = bus.cmd_code;
            dcnt_d             = '0;
            state_d            = ST_NUM_B;
          end else begin
            state_d = ST_NUM_A;
          end
        end

        ST_WAIT_OP: begin
          if (cmd_acc_s && is_op(code3_s)) begin
            stb_d.load_opcode = 1'b1;
            opcode_d          = bus.cmd_code;
            dcnt_d            = '0;
            state_d           = ST_NUM_B;
          end else begin
            state_d = ST_WAIT_OP;
          end
        end

        ST_NUM_B: begin
          if (!cmd_acc_s) begin
            state_d = ST_NUM_B;
          end else if (code3_s == CMD_DIGIT) begin
            if (dcnt_q < DW'(MAX_DIGITS)) begin
              stb_d.load_number = 1'b1;
              dcnt_d            = dcnt_q + DW'(1);
            end else begin
              dcnt_d = dcnt_q;
            end
          end else if (is_op(code3_s) && (dcnt_q == '0)) begin
            // Operator may be changed until the first digit of operand B.
            stb_d.load_opcode = 1'b1;
            opcode_d          = bus.cmd_code;
          end else if ((code3_s == CMD_ENTER) && (dcnt_q != '0)) begin
            state_d = ST_EXEC;
          end else begin
            state_d = ST_NUM_B;
          end
        end

        ST_EXEC: begin
          if (lat_last_s) begin
            if (bus.alu_err) begin
              state_d = ST_ERR;
            end else begin
              stb_d.load_result = 1'b1;
              exec_done_s       = 1'b1;
`ifdef CALC_REPEAT_EN
              stb_d.clear_number = 1'b0;
`else
              stb_d.clear_number = 1'b1;
`endif
              state_d = ST_SHOW;
            end
          end else begin
            state_d = ST_EXEC;
          end
        end

        ST_SHOW: begin
          if (bus.cmd_valid && (code3_s == CMD_DIGIT)) begin
            // Start a fresh calculation; the DIGIT itself is taken next cycle in IDLE.
            stb_d.clear_result = 1'b1;
            stb_d.clear_number = 1'b1;
            dcnt_d             = '0;
            state_d            = ST_IDLE;
          end else if (cmd_acc_s && is_op(code3_s)) begin
            // Chaining: the shown result becomes operand A.
            stb_d.load_opcode = 1'b1;
            opcode_d          = bus.cmd_code;
            dcnt_d            = '0;
            state_d           = ST_NUM_B;
`ifdef CALC_REPEAT_EN
          end else if (cmd_acc_s && (code3_s == CMD_ENTER)) begin
            // Repeat the last operation with operand B still in the number register.
            state_d = ST_EXEC;
`endif
          end else begin
            state_d = ST_SHOW;
          end
        end

        ST_ERR: begin
          state_d = ST_ERR;
        end

        default: begin
          dcnt_d  = '0;
          state_d = ST_IDLE;
        end
      endcase
    end

    lat_load_s = (state_d == ST_EXEC) && (state_q != ST_EXEC);
    sel_alu_d  = (state_d == ST_EXEC) || exec_done_s;
    sel_disp_d = (state_d == ST_SHOW) || (state_d == ST_ERR);
    err_d      = (state_d == ST_ERR);
  end

  // State, counters and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      dcnt_q     <= '0;
      opcode_q   <= '0;
      stb_q      <= '0;
      sel_alu_q  <= 1'b0;
      sel_disp_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      dcnt_q     <= dcnt_d;
      opcode_q   <= opcode_d;
      stb_q      <= stb_d;
      sel_alu_q  <= sel_alu_d;
      sel_disp_q <= sel_disp_d;
      err_q      <= err_d;
    end
  end

  assign bus.cmd_ready       = cmd_ready_s;
  assign bus.load_number     = stb_q.load_number;
  assign bus.clear_number    = stb_q.clear_number;
  assign bus.load_opcode     = stb_q.load_opcode;
  assign bus.clear_opcode    = stb_q.clear_opcode;
  assign bus.load_result     = stb_q.load_result;
  assign bus.clear_result    = stb_q.clear_result;
  assign bus.sel_mux_alu     = sel_alu_q;
  assign bus.sel_mux_display = sel_disp_q;
  assign bus.opcode_out      = opcode_q;
  assign bus.state_out       = state_q;
  assign bus.err             = err_q;

endmodule

// File: tb/tb_calc_ctrl_fsm.sv
// tb_calc_ctrl_fsm: directed, table-driven bench for calc_ctrl_fsm
// (MAX_DIGITS=2, ALU_LATENCY=3). Each vector is one clock cycle: inputs
// applied just after the rising edge, outputs compared on the falling edge.
module tb_calc_ctrl_fsm;

  typedef struct packed {
    logic       valid;
    logic [2:0] code;
    logic       aerr;
    logic       ready;
    logic [5:0] stb;      // {ln, cn, lo, co, lr, cr}
    logic       sel_alu;
    logic       sel_disp;
    logic [2:0] state;
    logic       err;
    logic [2:0] opc;
  } vec_t;

`ifdef CALC_REPEAT_EN
  localparam logic CN_END = 1'b0;
`else
  localparam logic CN_END = 1'b1;
`endif

  localparam logic [2:0] CLR = 3'b000;
  localparam logic [2:0] DIG = 3'b001;
  localparam logic [2:0] ENT = 3'b010;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_bad;
  vec_t tbl[$];

  calc_ctrl_fsm_if #(.OPCODE_W(3)) bus ();

  calc_ctrl_fsm #(
    .OPCODE_W    (3),
    .MAX_DIGITS  (2),
    .ALU_LATENCY (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic v, input logic [2:0] c, input logic ae,
                              input logic rdy, input logic [5:0] stb, input logic sa,
                              input logic sd, input logic [2:0] st, input logic er,
                              input logic [2:0] op);
    vec_t r;
    r.valid = v;  r.code = c;  r.aerr = ae;  r.ready = rdy;  r.stb = stb;
    r.sel_alu = sa;  r.sel_disp = sd;  r.state = st;  r.err = er;  r.opc = op;
    return r;
  endfunction

  // Drive one cycle of inputs, compare outputs on the falling edge, advance to the next cycle.
  task automatic run_vec(input vec_t v, input string name);
    vec_t a;
    bus.cmd_valid = v.valid;
    bus.cmd_code  = v.code;
    bus.alu_err   = v.aerr;
    @(negedge clk);
    a = v;
    a.ready    = bus.cmd_ready;
    a.stb      = {bus.load_number, bus.clear_number, bus.load_opcode,
                  bus.clear_opcode, bus.load_result, bus.clear_result};
    a.sel_alu  = bus.sel_mux_alu;
    a.sel_disp = bus.sel_mux_display;
    a.state    = bus.state_out;
    a.err      = bus.err;
    a.opc      = bus.opcode_out;
    n_vec++;
    if (a !== v) begin
      n_bad++;
      $display("FAIL %s: got rdy=%b stb=%b alu=%b disp=%b st=%0d err=%b opc=%0d, want rdy=%b stb=%b alu=%b disp=%b st=%0d err=%b opc=%0d",
               name, a.ready, a.stb, a.sel_alu, a.sel_disp, a.state, a.err, a.opc,
               v.ready, v.stb, v.sel_alu, v.sel_disp, v.state, v.err, v.opc);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    reset = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_code  = DIG;
    bus.alu_err   = 1'b0;
    @(posedge clk);
    #1;

    // Reset held three cycles: ready low even with a valid command.
    for (int i = 0; i < 3; i++) run_vec(mk(1'b1, DIG, 1'b0, 1'b0, 6'b000000, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0), "reset_hold");
    reset = 1'b0;
    run_vec(mk(1'b0, CLR, 1'b0, 1'b1, 6'b000000, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0), "reset_release");

    // Main table: add, SHOW->DIGIT, digit limit, opcode replace, error path, ignores.
    tbl.push_back(mk(1'b1, DIG,    1'b0, 1'b1, 6'b000000, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0));
    tbl.push_back(mk(1'b1, ENT,    1'b0, 1'b1, 6'b100000, 1'b0, 1'b0, 3'd1, 1'b0, 3'd0));
    tbl.push_back(mk(1'b1, 3'd4,   1'b0, 1'b1, 6'b010010, 1'b0, 1'b0, 3'd2, 1'b0, 3'd0));
    tbl.push_back(mk(1'b1, DIG,    1'b0, 1'b1, 6'b001000, 1'b0, 1'b0, 3'd3, 1'b0, 3'd4));
    tbl.push_back(mk(1'b1, ENT,    1'b0, 1'b1, 6'b100000, 1'b0, 1'b0, 3'd3, 1'b0, 3'd4));
    tbl.push_back(mk(1'b0, CLR,    1'b0, 1'b0, 6'b000000, 1'b1, 1'b0, 3'd4, 1'b0, 3'd4));
    tbl.push_back(mk(1'b0, CLR,    1'b0, 1'b0, 6'b000000, 1'b1, 1'b0, 3'd4, 1'b0, 3'd4));
    tbl.push_back(mk(1'b0, CLR,    1'b0, 1'b0, 6'b000000, 1'b1, 1'b0, 3'd4, 1'b0, 3'd4));
    tbl.push_back(mk(1'b0, CLR,    1'b0, 1'b1, {1'b0, CN_END, 4'b0010}, 1'b1, 1'b1, 3'd5, 1'b0, 3'd4));
    tbl.push_back(mk(1'b1, DIG,    1'b0, 1'b0, 6'b000000, 1'b0, 1'b1, 3'd5, 1'b0, 3'd4));
    tbl.push_back(mk(1'b1, DIG,    1'b0, 1'b1, 6'b010001, 1'b0, 1'b0, 3'd0, 1'b0, 3'd4));
    tbl.push_back(mk(1'b1, DIG,    1'b0, 1'b1, 6'b100000, 1'b0, 1'b0, 3'd1, 1'b0, 3'd4));
    tbl.push_back(mk(1'b1, DIG,    1'b0, 1'b1, 6'b100000, 1'b0, 1'b0, 3'd1, 1'b0, 3'd4));
    tbl.push_back(mk(1'b1, DIG,    1'b0, 1'b1, 6'b000000, 1'b0, 1'b0, 3'd1, 1'b0, 3'd4));
    tbl.push_back(mk(1'b1, 3'd7,   1'b0, 1'b1, 6'b000000, 1'b0, 1'b0, 3'd1, 1'b0, 3'd4));
    tbl.push_back(mk(1'b1, ENT,    1'b0, 1'b1, 6'b011010, 1'b0, 1'b0, 3'd3, 1'b0, 3'd7));
    tbl.push_back(mk(1'b1, 3'd5,   1'b0, 1'b1, 6'b000000, 1'b0, 1'b0, 3'd3, 1'b0, 3'd7));
    tbl.push_back(mk(1'b1, DIG,    1'b0, 1'b1, 6'b001000, 1'b0, 1'b0, 3'd3, 1'b0, 3'd5));
    tbl.push_back(mk(1'b1, 3'd6,   1'b0, 1'b1, 6'b100000, 1'b0, 1'b0, 3'd3, 1'b0, 3'd5));
    tbl.push_back(mk(1'b1, ENT,    1'b0, 1'b1, 6'b000000, 1'b0, 1'b0, 3'd3, 1'b0, 3'd5));
    tbl.push_back(mk(1'b1, DIG,    1'b0, 1'b0, 6'b000000, 1'b1, 1'b0, 3'd4, 1'b0, 3'd5));
    tbl.push_back(mk(1'b0, CLR,    1'b0, 1'b0, 6'b000000, 1'b1, 1'b0, 3'd4, 1'b0, 3'd5));
    tbl.push_back(mk(1'b0, CLR,    1'b1, 1'b0, 6'b000000, 1'b1, 1'b0, 3'd4, 1'b0, 3'd5));
    tbl.push_back(mk(1'b1, DIG,    1'b0, 1'b1, 6'b000000, 1'b0, 1'b1, 3'd6, 1'b1, 3'd5));
    tbl.push_back(mk(1'b1, ENT,    1'b0, 1'b1, 6'b000000, 1'b0, 1'b1, 3'd6, 1'b1, 3'd5));
    tbl.push_back(mk(1'b1, CLR,    1'b0, 1'b1, 6'b000000, 1'b0, 1'b1, 3'd6, 1'b1, 3'd5));
    tbl.push_back(mk(1'b1, 3'd3,   1'b0, 1'b1, 6'b010101, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0));
    tbl.push_back(mk(1'b1, ENT,    1'b0, 1'b1, 6'b000000, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0));
    tbl.push_back(mk(1'b1, 3'd4,   1'b0, 1'b1, 6'b000000, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0));
    tbl.push_back(mk(1'b1, DIG,    1'b0, 1'b1, 6'b000000, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0));
    tbl.push_back(mk(1'b1, ENT,    1'b0, 1'b1, 6'b100000, 1'b0, 1'b0, 3'd1, 1'b0, 3'd0));
    tbl.push_back(mk(1'b1, DIG,    1'b0, 1'b1, 6'b010010, 1'b0, 1'b0, 3'd2, 1'b0, 3'd0));
    tbl.push_back(mk(1'b1, ENT,    1'b0, 1'b1, 6'b000000, 1'b0, 1'b0, 3'd2, 1'b0, 3'd0));
    tbl.push_back(mk(1'b1, CLR,    1'b0, 1'b1, 6'b000000, 1'b0, 1'b0, 3'd2, 1'b0, 3'd0));
    tbl.push_back(mk(1'b0, CLR,    1'b0, 1'b1, 6'b010101, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0));
    tbl.push_back(mk(1'b0, CLR,    1'b0, 1'b1, 6'b000000, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0));
    foreach (tbl[i]) run_vec(tbl[i], $sformatf("tbl[%0d]", i));

    // Reach SHOW with an add, then exercise ENTER in SHOW.
    run_vec(mk(1'b1, DIG,  1'b0, 1'b1, 6'b000000, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0), "show_s0");
    run_vec(mk(1'b1, 3'd4, 1'b0, 1'b1, 6'b100000, 1'b0, 1'b0, 3'd1, 1'b0, 3'd0), "show_s1");
    run_vec(mk(1'b1, DIG,  1'b0, 1'b1, 6'b011010, 1'b0, 1'b0, 3'd3, 1'b0, 3'd4), "show_s2");
    run_vec(mk(1'b1, ENT,  1'b0, 1'b1, 6'b100000, 1'b0, 1'b0, 3'd3, 1'b0, 3'd4), "show_s3");
    for (int i = 0; i < 3; i++) run_vec(mk(1'b0, CLR, 1'b0, 1'b0, 6'b000000, 1'b1, 1'b0, 3'd4, 1'b0, 3'd4), "show_exec");
    run_vec(mk(1'b1, ENT, 1'b0, 1'b1, {1'b0, CN_END, 4'b0010}, 1'b1, 1'b1, 3'd5, 1'b0, 3'd4), "show_s7");
`ifdef CALC_REPEAT_EN
    for (int i = 0; i < 3; i++) run_vec(mk(1'b0, CLR, 1'b0, 1'b0, 6'b000000, 1'b1, 1'b0, 3'd4, 1'b0, 3'd4), "rep1_exec");
    run_vec(mk(1'b1, ENT, 1'b0, 1'b1, 6'b000010, 1'b1, 1'b1, 3'd5, 1'b0, 3'd4), "rep1_show");
    for (int i = 0; i < 3; i++) run_vec(mk(1'b0, CLR, 1'b0, 1'b0, 6'b000000, 1'b1, 1'b0, 3'd4, 1'b0, 3'd4), "rep2_exec");
    run_vec(mk(1'b1, CLR, 1'b0, 1'b1, 6'b000010, 1'b1, 1'b1, 3'd5, 1'b0, 3'd4), "rep2_show");
    run_vec(mk(1'b0, CLR, 1'b0, 1'b1, 6'b010101, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0), "rep_clear");
`else
    run_vec(mk(1'b1, ENT,  1'b0, 1'b1, 6'b000000, 1'b0, 1'b1, 3'd5, 1'b0, 3'd4), "enter_ignored1");
    run_vec(mk(1'b1, 3'd6, 1'b0, 1'b1, 6'b000000, 1'b0, 1'b1, 3'd5, 1'b0, 3'd4), "enter_ignored2");
    run_vec(mk(1'b1, CLR,  1'b0, 1'b1, 6'b001000, 1'b0, 1'b0, 3'd3, 1'b0, 3'd6), "chain_op");
    run_vec(mk(1'b0, CLR,  1'b0, 1'b1, 6'b010101, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0), "chain_clear");
`endif

    // Reset asserted mid-EXEC: abort without load_result or err.
    run_vec(mk(1'b1, DIG,  1'b0, 1'b1, 6'b000000, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0), "rst_exec_r0");
    run_vec(mk(1'b1, 3'd4, 1'b0, 1'b1, 6'b100000, 1'b0, 1'b0, 3'd1, 1'b0, 3'd0), "rst_exec_r1");
    run_vec(mk(1'b1, DIG,  1'b0, 1'b1, 6'b011010, 1'b0, 1'b0, 3'd3, 1'b0, 3'd4), "rst_exec_r2");
    run_vec(mk(1'b1, ENT,  1'b0, 1'b1, 6'b100000, 1'b0, 1'b0, 3'd3, 1'b0, 3'd4), "rst_exec_r3");
    run_vec(mk(1'b0, CLR,  1'b0, 1'b0, 6'b000000, 1'b1, 1'b0, 3'd4, 1'b0, 3'd4), "rst_exec_r4");
    reset = 1'b1;
    run_vec(mk(1'b0, CLR,  1'b0, 1'b0, 6'b000000, 1'b1, 1'b0, 3'd4, 1'b0, 3'd4), "rst_exec_r5");
    reset = 1'b0;
    run_vec(mk(1'b0, CLR,  1'b0, 1'b1, 6'b000000, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0), "rst_exec_r6");
    run_vec(mk(1'b0, CLR,  1'b0, 1'b1, 6'b000000, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0), "rst_exec_r7");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
